// File: rtl/vga_write_arbiter.sv
// vga_write_arbiter: round-robin arbiter that shares the single pixel-write
// port of the VGA adapter among NUM_REQ renderers. Off-screen pixels are
// consumed but dropped, and a sticky flag records that one was dropped.
// Outputs to the adapter are registered, giving one cycle of latency.
// Optional feature macro: VGA_CLEAR_ENGINE_EN. When it is defined, a
// clear engine can own the port and paint every pixel of the frame.
module vga_write_arbiter #(
    parameter int NUM_REQ  = 3,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 18,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic                         clock,
    input  logic                         resetn,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*X_W-1:0]       req_x,
    input  logic [NUM_REQ*Y_W-1:0]       req_y,
    input  logic [NUM_REQ*COLOUR_W-1:0]  req_colour,
    output logic [NUM_REQ-1:0]           ack,
    input  logic                         clear_start,
    input  logic [COLOUR_W-1:0]          clear_colour,
    output logic                         clear_busy,
    output logic                         oob_err,
    output logic [X_W-1:0]               vga_x,
    output logic [Y_W-1:0]               vga_y,
    output logic [COLOUR_W-1:0]          vga_colour,
    output logic                         vga_write
);
    localparam int LW = $clog2(NUM_REQ);

    logic [LW-1:0]       last_q, last_d;
    logic [X_W-1:0]      x_q, x_d;
    logic [Y_W-1:0]      y_q, y_d;
    logic [COLOUR_W-1:0] col_q, col_d;
    logic                wr_q, wr_d;
    logic                oob_q, oob_d;
    logic                busy_q, busy_d;

    logic [LW-1:0]       gnt_idx;
    logic                gnt_vld;
    logic [X_W-1:0]      sel_x;
    logic [Y_W-1:0]      sel_y;
    logic [COLOUR_W-1:0] sel_col;
    logic                on_screen;

    logic [X_W-1:0]      rx [NUM_REQ];
    logic [Y_W-1:0]      ry [NUM_REQ];
    logic [COLOUR_W-1:0] rc [NUM_REQ];

    // Unpack the flat per-requester buses into indexable arrays.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign rx[g] = req_x[g*X_W +: X_W];
        assign ry[g] = req_y[g*Y_W +: Y_W];
        assign rc[g] = req_colour[g*COLOUR_W +: COLOUR_W];
    end

    // Round-robin search starting just after the last winner; blocked by the
    // clear engine and held off while in reset.
    always_comb begin
        int idx;
        idx     = 0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        ack     = '0;
        if (resetn && !busy_q) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                idx = (int'(last_q) + k) % NUM_REQ;
                if (!gnt_vld && req[idx]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = LW'(idx);
                end
            end
        end
        if (gnt_vld) ack[gnt_idx] = 1'b1;
    end

    assign sel_x     = rx[gnt_idx];
    assign sel_y     = ry[gnt_idx];
    assign sel_col   = rc[gnt_idx];
    assign on_screen = (int'(sel_x) < SCREEN_W) && (int'(sel_y) < SCREEN_H);

`ifdef VGA_CLEAR_ENGINE_EN
    localparam logic [X_W-1:0] CX_LAST = X_W'(SCREEN_W - 1);
    localparam logic [Y_W-1:0] CY_LAST = Y_W'(SCREEN_H - 1);

    logic [X_W-1:0] cx_q, cx_d;
    logic [Y_W-1:0] cy_q, cy_d;

    // Next state: clear scan owns the port while busy, otherwise the winner.
    always_comb begin
        last_d = last_q;
        x_d    = x_q;
        y_d    = y_q;
        col_d  = col_q;
        wr_d   = 1'b0;
        oob_d  = oob_q;
        busy_d = busy_q;
        cx_d   = cx_q;
        cy_d   = cy_q;
        if (busy_q) begin
            x_d   = cx_q;
            y_d   = cy_q;
            col_d = clear_colour;
            wr_d  = 1'b1;
            if (cx_q == CX_LAST) begin
                cx_d = '0;
                if (cy_q == CY_LAST) begin
                    cy_d   = '0;
                    busy_d = 1'b0;
                end else begin
                    cy_d = cy_q + Y_W'(1);
                end
            end else begin
                cx_d = cx_q + X_W'(1);
            end
        end else begin
            if (gnt_vld) begin
                last_d = gnt_idx;
                if (on_screen) begin
                    x_d   = sel_x;
                    y_d   = sel_y;
                    col_d = sel_col;
                    wr_d  = 1'b1;
                end else begin
                    oob_d = 1'b1;
                end
            end
            // A grant in the start cycle still completes above.
            if (clear_start) begin
                busy_d = 1'b1;
                cx_d   = '0;
                cy_d   = '0;
            end
        end
    end

    // Clear scan counters.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cx_q <= '0;
            cy_q <= '0;
        end else begin
            cx_q <= cx_d;
            cy_q <= cy_d;
        end
    end
`else
    logic unused_clear;
    assign unused_clear = ^{clear_start, clear_colour};

    // Next state: only requester transfers can reach the port.
    always_comb begin
        last_d = last_q;
        x_d    = x_q;
        y_d    = y_q;
        col_d  = col_q;
        wr_d   = 1'b0;
        oob_d  = oob_q;
        busy_d = 1'b0;
        if (gnt_vld) begin
            last_d = gnt_idx;
            if (on_screen) begin
                x_d   = sel_x;
                y_d   = sel_y;
                col_d = sel_col;
                wr_d  = 1'b1;
            end else begin
                oob_d = 1'b1;
            end
        end
    end
`endif

    // Arbiter pointer, adapter-facing registers and status flags.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            last_q <= LW'(NUM_REQ - 1);
            x_q    <= '0;
            y_q    <= '0;
            col_q  <= '0;
            wr_q   <= 1'b0;
            oob_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            last_q <= last_d;
            x_q    <= x_d;
            y_q    <= y_d;
            col_q  <= col_d;
            wr_q   <= wr_d;
            oob_q  <= oob_d;
            busy_q <= busy_d;
        end
    end

    assign vga_x      = x_q;
    assign vga_y      = y_q;
    assign vga_colour = col_q;
    assign vga_write  = wr_q;
    assign oob_err    = oob_q;
    assign clear_busy = busy_q;

endmodule
